// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared mode/key constants for the SAP-1 clock controller
package clock_ctrl_pkg;
  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_FAST   = 2'd2;
  localparam int KEY_STEP = 0;
  localparam int KEY_SLOW = 1;
  localparam int KEY_FAST = 2;
  localparam int KEY_CLR  = 3;
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_MANUAL : m;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchroniser, stable-sample debouncer and press-edge pulse for one active-low key
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  // level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        press_q <= ~sync_q[1];
      end else cnt_q <= cnt_q + CW'(1);
    end
  assign pressed_o = ~level_q;
  assign press_o   = press_q;
endmodule

// File: rtl/clock_controller.sv
// clock_controller: SAP-1 clock-enable, speed, halt and clear controller
module clock_controller import clock_ctrl_pkg::*; #(
  parameter  int CLK_HZ          = 50_000_000,
  parameter  int BASE_TICK_HZ    = 10,
  parameter  int NUM_SPEEDS      = 4,
  parameter  int DEBOUNCE_CYCLES = 1_000_000,
  localparam int SPD_W           = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             ie_n,
  input  logic [3:0]       key_n,
  input  logic             halt,
  output logic             clk_en,
  output logic             clk_level,
  output logic             clr_out,
  output logic [SPD_W-1:0] speed,
  output logic             halted
);
  localparam int TICK_DIV = CLK_HZ / BASE_TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV + 1);
  logic [3:0]       pressed, press;
  logic [1:0]       mode_n, mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SPD_W-1:0] per_q, per_d, speed_q, speed_d;
  logic             halted_q, halted_d, en_q, en_d, lvl_q, lvl_d, clr_out_q, clr_out_d;
  logic             chg, clear, idle, tick, fire, up, dn, want;
  logic             unused_keys;
  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk      (clk),
      .clr      (clr),
      .key_n_i  (key_n[k] | ie_n),
      .pressed_o(pressed[k]),
      .press_o  (press[k])
    );
  end
  assign unused_keys = ^{press[KEY_CLR], pressed[KEY_FAST:KEY_STEP]};
  // next state: clear dominates, then mode change restarts the auto counters, halt gates clk_en
  always_comb begin
    mode_n    = norm_mode(mode);
    mode_d    = mode_n;
    chg       = mode_n != mode_q;
    clear     = pressed[KEY_CLR];
    idle      = mode_n != MODE_AUTO || chg || clear;
    tick      = presc_q == PW'(TICK_DIV - 1);
    fire      = tick && per_q >= speed_q;
    presc_d   = (idle || tick) ? '0 : presc_q + PW'(1);
    per_d     = (idle || fire) ? '0 : tick ? per_q + SPD_W'(1) : per_q;
    up        = press[KEY_SLOW] && !press[KEY_FAST] && speed_q != SPD_W'(NUM_SPEEDS - 1);
    dn        = press[KEY_FAST] && !press[KEY_SLOW] && speed_q != '0;
    speed_d   = clear ? '0 : up ? speed_q + SPD_W'(1) : dn ? speed_q - SPD_W'(1) : speed_q;
    halted_d  = !clear && (halted_q || halt);
    want      = (mode_n == MODE_FAST) ? 1'b1 : (mode_n == MODE_AUTO) ? fire : press[KEY_STEP];
    en_d      = want && !chg && !clear && !halted_q && !halt;
    lvl_d     = !clear && (lvl_q ^ en_d);
    clr_out_d = !clear;
  end
  // state and output registers
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      mode_q    <= MODE_MANUAL;
      presc_q   <= '0;
      per_q     <= '0;
      speed_q   <= '0;
      halted_q  <= 1'b0;
      en_q      <= 1'b0;
      lvl_q     <= 1'b0;
      clr_out_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      per_q     <= per_d;
      speed_q   <= speed_d;
      halted_q  <= halted_d;
      en_q      <= en_d;
      lvl_q     <= lvl_d;
      clr_out_q <= clr_out_d;
    end
  assign clk_en    = en_q;
  assign clk_level = lvl_q;
  assign clr_out   = clr_out_q;
  assign speed     = speed_q;
  assign halted    = halted_q;
endmodule
